// File: rtl/periph_bridge_pkg.sv
// Shared definitions for the data-side peripheral bridge: FSM encodings,
// error read data and the default SoC peripheral address map.
package periph_bridge_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_ERR    = 2'd2;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   localparam logic [31:0] MTIME_BASE = 32'h0000_8000;
   localparam logic [31:0] MTIME_MASK = 32'hFFFF_FFF0;
   localparam logic [31:0] UART_BASE  = 32'h0000_8010;
   localparam logic [31:0] UART_MASK  = 32'hFFFF_FFFC;
   localparam logic [31:0] GPIO_BASE  = 32'h0000_8020;
   localparam logic [31:0] GPIO_MASK  = 32'hFFFF_FFF0;
   localparam logic [31:0] TIMER_BASE = 32'h0000_8030;
   localparam logic [31:0] TIMER_MASK = 32'hFFFF_FFF0;

   // Slave k lives in bits [32k+31:32k]; slave 0 is the rightmost word.
   localparam logic [127:0] DEF_SLV_BASE = {TIMER_BASE, GPIO_BASE, UART_BASE, MTIME_BASE};
   localparam logic [127:0] DEF_SLV_MASK = {TIMER_MASK, GPIO_MASK, UART_MASK, MTIME_MASK};

endpackage

// File: rtl/periph_bridge_decode.sv
// Combinational priority address matcher: lowest-indexed matching slave wins,
// miss flags an access that matches no slave.
module periph_decode
   import periph_bridge_pkg::*;
#(
   parameter int                 NSLV     = 4,
   parameter logic [NSLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
   parameter logic [NSLV*32-1:0] SLV_MASK = DEF_SLV_MASK
) (
   input  logic [31:0]     addr_i,
   output logic [NSLV-1:0] sel_o,
   output logic            miss_o
);

   logic [NSLV-1:0] hit;

   // NOTE: every variable written in always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hit = '0;
      for (int k = 0; k < NSLV; k++) begin
         hit[k] = ((addr_i & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]);
      end
   end

   // Isolating the lowest set bit gives the priority one-hot select.
   assign sel_o  = hit & (~hit + NSLV'(1));
   assign miss_o = ~|hit;

endmodule

// File: rtl/periph_bridge.sv
// Data-side peripheral bridge: decodes core accesses onto NSLV slaves through a
// registered request stage, stalls on slave wait states, reports timeouts and misses.
module periph_bridge
   import periph_bridge_pkg::*;
#(
   parameter int                 NSLV     = 4,
   parameter logic [NSLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
   parameter logic [NSLV*32-1:0] SLV_MASK = DEF_SLV_MASK,
   parameter int                 TIMEOUT  = 16,
   parameter logic [31:0]        ERR_DATA = ERR_DATA_DEF
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 req_i,
   input  logic [31:0]          addr_i,
   input  logic [31:0]          wdata_i,
   input  logic [3:0]           wmask_i,
   input  logic                 wen_i,
   output logic [31:0]          rdata_o,
   output logic                 stall_o,
   output logic                 err_o,
   output logic [31:0]          err_addr_o,
   output logic [NSLV-1:0]      csb_o,
   output logic [31:0]          addr_o,
   output logic [31:0]          wdata_o,
   output logic [3:0]           wmask_o,
   output logic                 wen_o,
   input  logic [NSLV*32-1:0]   sdata_i,
   input  logic [NSLV-1:0]      sready_i
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [NSLV-1:0]  sel_q, sel_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wmask_q, wmask_d;
   logic             wen_q, wen_d;
   logic [31:0]      err_addr_q, err_addr_d;

   logic [NSLV-1:0]  dec_sel;
   logic             dec_miss;
   logic             sel_ready;
   logic [31:0]      sel_rdata;
   logic             can_accept;

   periph_decode #(
      .NSLV     (NSLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_decode (
      .addr_i (addr_i),
      .sel_o  (dec_sel),
      .miss_o (dec_miss)
   );

   // Only the selected slave's ready and data are observed.
   assign sel_ready = |(sready_i & sel_q);
   always_comb begin
      sel_rdata = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (sel_q[k]) sel_rdata = sel_rdata | sdata_i[32*k +: 32];
      end
   end

   // The completion cycle accepts a new request, so back-to-back accesses skip IDLE.
   assign can_accept = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && sel_ready);
   assign cnt_inc    = cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      wen_d      = wen_q;
      err_addr_d = err_addr_q;
      case (state_q)
         ST_ACCESS: begin
            if (sel_ready) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == CNT_LAST) begin
               state_d    = ST_ERR;
               cnt_d      = '0;
               err_addr_d = addr_q;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (req_i && can_accept) begin
         if (dec_miss) begin
            state_d    = ST_ERR;
            err_addr_d = addr_i;
         end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            sel_d   = dec_sel;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            wmask_d = wmask_i;
            wen_d   = wen_i;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sel_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         wen_q      <= 1'b1;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wmask_q    <= wmask_d;
         wen_q      <= wen_d;
         err_addr_q <= err_addr_d;
      end
   end

   // Chip selects derive from reset flops, so reset releases them immediately.
   always_comb begin
      csb_o   = '1;
      rdata_o = '0;
      stall_o = 1'b0;
      err_o   = 1'b0;
      case (state_q)
         ST_ACCESS: begin
            csb_o   = ~sel_q;
            stall_o = ~sel_ready;
            if (sel_ready) rdata_o = sel_rdata;
         end
         ST_ERR: begin
            rdata_o = ERR_DATA;
            err_o   = 1'b1;
         end
         default: ;
      endcase
   end

   assign addr_o     = addr_q;
   assign wdata_o    = wdata_q;
   assign wmask_o    = wmask_q;
   assign wen_o      = wen_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_periph_bridge.sv
// Bench for periph_bridge: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_periph_bridge;

   localparam int TO = 16;
   localparam logic [31:0] BASE_T [4] = '{32'h0000_8000, 32'h0000_8010, 32'h0000_8020, 32'h0000_8030};
   localparam logic [31:0] MASK_T [4] = '{32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

   logic         clk = 1'b0;
   logic         reset_i;
   logic         req;
   logic [31:0]  addr, wdata;
   logic [3:0]   wmask;
   logic         wen;
   logic [127:0] sdata;
   logic [3:0]   sready;

   logic [31:0]  rdata, err_addr, addr_o, wdata_o;
   logic         stall, err, wen_o;
   logic [3:0]   csb, wmask_o;

   logic [31:0]  o_rdata, o_err_addr, o_addr, o_wdata;
   logic         o_stall, o_err, o_wen;
   logic [3:0]   o_csb, o_wmask;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   periph_bridge #(.NSLV(4), .TIMEOUT(TO)) dut (
      .clk_i(clk), .reset_i(reset_i), .req_i(req), .addr_i(addr), .wdata_i(wdata),
      .wmask_i(wmask), .wen_i(wen), .rdata_o(rdata), .stall_o(stall), .err_o(err),
      .err_addr_o(err_addr), .csb_o(csb), .addr_o(addr_o), .wdata_o(wdata_o),
      .wmask_o(wmask_o), .wen_o(wen_o), .sdata_i(sdata), .sready_i(sready)
   );

   // Second instance with slave 0 widened so that slaves 0 and 1 overlap at 0x8010.
   periph_bridge #(
      .NSLV(4), .TIMEOUT(TO),
      .SLV_MASK({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFE0})
   ) dut_ovl (
      .clk_i(clk), .reset_i(reset_i), .req_i(req), .addr_i(addr), .wdata_i(wdata),
      .wmask_i(wmask), .wen_i(wen), .rdata_o(o_rdata), .stall_o(o_stall), .err_o(o_err),
      .err_addr_o(o_err_addr), .csb_o(o_csb), .addr_o(o_addr), .wdata_o(o_wdata),
      .wmask_o(o_wmask), .wen_o(o_wen), .sdata_i(sdata), .sready_i(sready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else pass_cnt++;
   endtask

   function automatic int lookup(input logic [31:0] a);
      for (int k = 0; k < 4; k++) begin
         if ((a & MASK_T[k]) == BASE_T[k]) return k;
      end
      return -1;
   endfunction

   // Transaction model: an in-flight access (slave, captured request, stall count)
   // or a pending one-cycle error response.
   bit          m_busy, m_err;
   int          m_wait, m_slave;
   logic [31:0] m_addr, m_wdata, m_err_addr;
   logic [3:0]  m_wmask;
   logic        m_wen;

   always @(negedge clk) begin : compare
      logic [3:0]  e_csb;
      logic [31:0] e_rdata;
      logic        e_stall, e_err;
      bit          done, timed_out, free;
      int          s;
      e_csb = 4'hF; e_rdata = '0; e_stall = 1'b0; e_err = 1'b0; done = 1'b0;
      if (!reset_i) begin
         m_busy = 0; m_err = 0; m_wait = 0; m_slave = 0;
         m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = 1'b1; m_err_addr = '0;
      end else if (m_err) begin
         e_rdata = 32'hDEAD_BEEF;
         e_err   = 1'b1;
      end else if (m_busy) begin
         done           = sready[m_slave];
         e_csb[m_slave] = 1'b0;
         e_stall        = !done;
         if (done) e_rdata = sdata[32*m_slave +: 32];
      end
      check("csb", 32'(csb), 32'(e_csb));
      check("stall", 32'(stall), 32'(e_stall));
      check("err", 32'(err), 32'(e_err));
      check("rdata", rdata, e_rdata);
      check("addr_o", addr_o, m_addr);
      check("wdata_o", wdata_o, m_wdata);
      check("wmask_o", 32'(wmask_o), 32'(m_wmask));
      check("wen_o", 32'(wen_o), 32'(m_wen));
      check("err_addr", err_addr, m_err_addr);
      if (reset_i) begin
         timed_out = m_busy && !done && (m_wait + 1 == TO - 1);
         free      = !m_err && (!m_busy || done);
         m_err     = 0;
         if (timed_out) begin
            m_busy = 0; m_err = 1; m_err_addr = m_addr;
         end else if (free && req) begin
            s = lookup(addr);
            if (s < 0) begin
               m_busy = 0; m_err = 1; m_err_addr = addr;
            end else begin
               m_busy = 1; m_wait = 0; m_slave = s;
               m_addr = addr; m_wdata = wdata; m_wmask = wmask; m_wen = wen;
            end
         end else if (done) begin
            m_busy = 0;
         end else if (m_busy) begin
            m_wait++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      req = 1'b0; addr = '0; wdata = '0; wmask = '0; wen = 1'b1; sready = '0;
   endtask

   int  stall_n, csb_n, err_n, err_cyc, pick;
   bit  stable, stall_seen;
   logic [31:0] err_rd;
   logic [3:0]  err_csb;

   initial begin
      reset_i = 1'b0;
      idle_in();
      sdata = '0;
      @(negedge clk);
      check("rst_csb", 32'(csb), 32'hF);
      check("rst_wen_o", 32'(wen_o), 32'h1);
      check("rst_rdata", rdata, 32'h0);
      tick();
      reset_i = 1'b1;

      // Zero-wait read of slave 1.
      tick();
      req = 1'b1; addr = 32'h0000_8010; wen = 1'b1; sready = 4'hF;
      sdata = {32'h0000_0033, 32'h0000_0022, 32'h0000_00A5, 32'h0000_0011};
      @(negedge clk); stall_seen = stall;
      tick(); req = 1'b0;
      @(negedge clk); stall_seen |= stall;
      check("zw_csb", 32'(csb), 32'hD);
      check("zw_rdata", rdata, 32'h0000_00A5);
      tick();
      @(negedge clk); stall_seen |= stall;
      check("zw_csb_release", 32'(csb), 32'hF);
      check("zw_no_stall", 32'(stall_seen), 32'h0);

      // Write with three wait states on slave 0.
      stall_n = 0; csb_n = 0; stable = 1;
      for (int c = 0; c < 8; c++) begin
         tick();
         req = (c <= 3); addr = 32'h0000_8004; wdata = 32'h1234_5678; wmask = 4'hF;
         wen = (c <= 3) ? 1'b0 : 1'b1;
         sready = (c == 4) ? 4'h1 : 4'h0;
         @(negedge clk);
         if (stall) stall_n++;
         if (!csb[0]) begin
            csb_n++;
            if (addr_o !== 32'h0000_8004 || wdata_o !== 32'h1234_5678 || wmask_o !== 4'hF || wen_o !== 1'b0)
               stable = 0;
         end
      end
      check("ws_stall_cycles", 32'(stall_n), 32'd3);
      check("ws_csb_cycles", 32'(csb_n), 32'd4);
      check("ws_stable", 32'(stable), 32'h1);

      // Timeout on slave 2.
      stall_n = 0; err_n = 0; err_cyc = -1; err_rd = '0; err_csb = '0;
      for (int c = 0; c < 21; c++) begin
         tick();
         req = (c < 16); addr = 32'h0000_8020; wen = 1'b1; sready = 4'h0;
         @(negedge clk);
         if (stall) stall_n++;
         if (err) begin
            err_n++; err_cyc = c; err_rd = rdata; err_csb = csb;
         end
      end
      check("to_stall_cycles", 32'(stall_n), 32'd15);
      check("to_err_pulses", 32'(err_n), 32'd1);
      check("to_err_cycle", 32'(err_cyc), 32'd16);
      check("to_err_rdata", err_rd, 32'hDEAD_BEEF);
      check("to_err_csb", 32'(err_csb), 32'hF);
      check("to_err_addr", err_addr, 32'h0000_8020);

      // Unmapped address.
      stall_n = 0; csb_n = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         req = (c == 0); addr = 32'h0001_0000; wen = 1'b1; sready = 4'hF;
         @(negedge clk);
         if (stall) stall_n++;
         if (csb != 4'hF) csb_n++;
         if (c == 1) begin
            check("um_err", 32'(err), 32'h1);
            check("um_err_addr", err_addr, 32'h0001_0000);
            check("um_rdata", rdata, 32'hDEAD_BEEF);
         end
      end
      check("um_no_stall", 32'(stall_n), 32'd0);
      check("um_no_csb", 32'(csb_n), 32'd0);

      // Overlapping decode with back-to-back zero-wait reads.
      sdata = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
      for (int c = 0; c < 4; c++) begin
         tick();
         req = (c <= 1); addr = 32'h0000_8010; wen = 1'b1; sready = 4'hF;
         @(negedge clk);
         case (c)
            1: begin
               check("ov_csb_first", 32'(o_csb), 32'hE);
               check("ov_rdata_first", o_rdata, 32'h0000_0011);
            end
            2: begin
               check("ov_csb_second", 32'(o_csb), 32'hE);
               check("ov_rdata_second", o_rdata, 32'h0000_0011);
               check("b2b_main_csb", 32'(csb), 32'hD);
            end
            3: check("ov_csb_release", 32'(o_csb), 32'hF);
            default: ;
         endcase
      end

      // Asynchronous reset in the middle of a wait-state access.
      tick(); req = 1'b1; addr = 32'h0000_8004; wen = 1'b1; sready = 4'h0;
      tick();
      tick();
      #2 reset_i = 1'b0;
      #1;
      check("ar_csb_async", 32'(csb), 32'hF);
      check("ar_err", 32'(err), 32'h0);
      tick(); reset_i = 1'b1; req = 1'b0;
      @(negedge clk);
      check("ar_err_after", 32'(err), 32'h0);
      tick(); req = 1'b1; addr = 32'h0000_8010; sready = 4'hF;
      sdata = {32'h0, 32'h0, 32'h0000_005A, 32'h0};
      tick(); req = 1'b0;
      @(negedge clk);
      check("ar_next_csb", 32'(csb), 32'hD);
      check("ar_next_rdata", rdata, 32'h0000_005A);

      // Randomized traffic, with periodic windows of silent slaves to force timeouts.
      for (int c = 0; c < 3000; c++) begin
         tick();
         req  = ($urandom_range(0, 9) < 7);
         pick = int'($urandom_range(0, 5));
         if (pick < 4)       addr = BASE_T[pick] + 32'($urandom_range(0, 15));
         else if (pick == 4) addr = $urandom;
         else                addr = 32'h0000_8040 + 32'($urandom_range(0, 255));
         wdata  = $urandom;
         wmask  = 4'($urandom_range(0, 15));
         wen    = 1'($urandom_range(0, 1));
         sdata  = {$urandom, $urandom, $urandom, $urandom};
         sready = (((c / 40) % 5) == 4) ? 4'h0 : 4'($urandom & $urandom);
      end

      tick();
      idle_in();
      repeat (3) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
